// File: rtl/single_port_synchronous_ram_if.sv
// Bus bundle for single_port_synchronous_ram.
// Signals: we (write enable), addr (word address), din (write data),
//          dout (registered read data).
// Modports: master drives we/addr/din and samples dout; slave is the RAM side.
interface single_port_synchronous_ram_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output we, output addr, output din, input dout);
  modport slave  (input we, input addr, input din, output dout);
endinterface

// File: rtl/single_port_synchronous_ram.sv
// Single-port synchronous RAM: 2^ADDR_WIDTH words of DATA_WIDTH bits,
// synchronous write, registered write-first read, one access per edge.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset; clears dout and blocks the write
//   bus  - slave modport: we, addr, din in; dout out (registered)
// Option: define SPRAM_RESET_CLEAR_EN to also zero every location on reset.
// Without it, reset leaves the array untouched so it can map to block RAM.
module single_port_synchronous_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  single_port_synchronous_ram_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;

`ifdef SPRAM_RESET_CLEAR_EN
  // Storage array; reset zeroes every location in a single edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (bus.we) begin
      mem[bus.addr] <= bus.din;
    end
  end
`else
  // Storage array; reset only suppresses the write, contents survive.
  always_ff @(posedge clk) begin
    if (!rst && bus.we) begin
      mem[bus.addr] <= bus.din;
    end
  end
`endif

  // Output register: write-first, so a write cycle returns din directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (bus.we) begin
      dout_q <= bus.din;
    end else begin
      dout_q <= mem[bus.addr];
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_single_port_synchronous_ram.sv
// Self-checking bench for single_port_synchronous_ram: directed scenarios
// followed by random traffic, all checked against an array-based model.
module tb_single_port_synchronous_ram;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk;
  logic rst;

  single_port_synchronous_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  single_port_synchronous_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents plus a flag for locations with a defined value.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_ok  [DEPTH];

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock edge with the given inputs; model predicts dout afterwards.
  task automatic op(input string tag, input bit r, input bit w,
                    input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    bit            known;
    @(negedge clk);
    rst      = r;
    bus.we   = w;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp   = '0;
      known = 1'b1;
`ifdef SPRAM_RESET_CLEAR_EN
      for (int i = 0; i < int'(DEPTH); i++) begin
        ref_mem[i] = '0;
        ref_ok[i]  = 1'b1;
      end
`endif
    end else if (w) begin
      ref_mem[a] = d;
      ref_ok[a]  = 1'b1;
      exp        = d;
      known      = 1'b1;
    end else begin
      exp   = ref_mem[a];
      known = ref_ok[a];
    end
    if (known) check(tag, bus.dout, exp);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = '0;
      ref_ok[i]  = 1'b0;
    end
    rst      = 1'b1;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.din  = '0;

    // Reset edge with a pending write: dout clears, no write happens.
    op("rst_dout", 1'b1, 1'b1, 4'h3, 8'hFF);
    op("rst_rd3", 1'b0, 1'b0, 4'h3, 8'h00);
    check("rst_nowrite", {7'b0, bus.dout === 8'hFF}, 8'h00);

    // Write then read back, write-first visible on dout.
    op("wr2", 1'b0, 1'b1, 4'h2, 8'hAA);
    op("wr4", 1'b0, 1'b1, 4'h4, 8'h55);
    op("rd2", 1'b0, 1'b0, 4'h2, 8'h00);
    op("rd4", 1'b0, 1'b0, 4'h4, 8'h00);
    op("rd4_held", 1'b0, 1'b0, 4'h4, 8'h00);

    // dout must not follow addr between edges.
    @(negedge clk);
    bus.addr = 4'h2;
    #1;
    check("hold_no_edge", bus.dout, 8'h55);

    // Overwrite: last write wins.
    op("wr7a", 1'b0, 1'b1, 4'h7, 8'h11);
    op("wr7b", 1'b0, 1'b1, 4'h7, 8'h22);
    op("rd7", 1'b0, 1'b0, 4'h7, 8'h00);

    // Full address sweep.
    for (int i = 0; i < int'(DEPTH); i++)
      op("sweep_wr", 1'b0, 1'b1, AW'(i), DW'(i) ^ 8'h5A);
    for (int i = 0; i < int'(DEPTH); i++)
      op("sweep_rd", 1'b0, 1'b0, AW'(i), 8'h00);
    check("sweep_pat15", bus.dout, 8'h0F ^ 8'h5A);

    // Reset mid-stream with a pending write to the same address.
    op("mid_wr1", 1'b0, 1'b1, 4'h1, 8'hC3);
    op("mid_rst", 1'b1, 1'b1, 4'h1, 8'h00);
    op("mid_rd1", 1'b0, 1'b0, 4'h1, 8'h00);
`ifdef SPRAM_RESET_CLEAR_EN
    check("mid_rd1_val", bus.dout, 8'h00);
    for (int i = 0; i < int'(DEPTH); i++)
      op("clr_rd", 1'b0, 1'b0, AW'(i), 8'h00);
`else
    check("mid_rd1_val", bus.dout, 8'hC3);
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      op("rand",
         $urandom_range(0, 24) == 0,
         $urandom_range(0, 1) == 1,
         AW'($urandom_range(0, int'(DEPTH) - 1)),
         DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
